// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the fetch/decode stage: opcodes, ALU codes, FSM states
// and the decoded control bundle.
package cpu_defs_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  typedef struct packed {
    logic       write;
    logic [2:0] aluop;
    logic       neg_sel;
    logic       imm_sel;
    logic       illegal;
    logic       jump;
    logic       beq;
  } ctrl_t;

  // Word offset in the instruction becomes a signed byte offset.
  function automatic logic [31:0] branch_offset(input logic [7:0] off);
    return {{22{off[7]}}, off, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Instruction memory busywait handshake between the fetch stage and memory.
interface fetch_decode_unit_if;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_READ;
  logic [31:0] IMEM_INSTR;
  logic        IMEM_BUSYWAIT;

  modport master (output IMEM_ADDR, output IMEM_READ,
                  input  IMEM_INSTR, input IMEM_BUSYWAIT);
  modport slave  (input  IMEM_ADDR, input IMEM_READ,
                  output IMEM_INSTR, output IMEM_BUSYWAIT);
endinterface

// File: rtl/instr_decoder.sv
// Combinational opcode decode; every control is forced low unless exec is set.
module instr_decoder
  import cpu_defs_pkg::*;
(
  input  logic [7:0] opcode,
  input  logic       exec,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    if (exec) begin
      case (opcode)
        OP_LOADI: begin
          ctrl.write   = 1'b1;
          ctrl.imm_sel = 1'b1;
          ctrl.aluop   = ALU_FWD;
        end
        OP_MOV: begin
          ctrl.write = 1'b1;
          ctrl.aluop = ALU_FWD;
        end
        OP_ADD: begin
          ctrl.write = 1'b1;
          ctrl.aluop = ALU_ADD;
        end
        OP_SUB: begin
          ctrl.write   = 1'b1;
          ctrl.aluop   = ALU_ADD;
          ctrl.neg_sel = 1'b1;
        end
        OP_AND: begin
          ctrl.write = 1'b1;
          ctrl.aluop = ALU_AND;
        end
        OP_OR: begin
          ctrl.write = 1'b1;
          ctrl.aluop = ALU_OR;
        end
        OP_J: begin
          ctrl.jump = 1'b1;
        end
        OP_BEQ: begin
          // ALU subtracts src2 from src1 so ZERO reports equality
          ctrl.beq     = 1'b1;
          ctrl.aluop   = ALU_ADD;
          ctrl.neg_sel = 1'b1;
        end
        default: begin
          ctrl.illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Multi-cycle fetch/decode stage: PC, IR and a FETCH/EXEC FSM, one instruction
// in flight, resolving j/beq at the EXEC edge.
module fetch_decode_unit
  import cpu_defs_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic                       CLK,
  input  logic                       RESET,
  fetch_decode_unit_if.master        imem,
  input  logic                       ZERO,
  output logic [2:0]                 INADDRESS,
  output logic [2:0]                 OUT1ADDRESS,
  output logic [2:0]                 OUT2ADDRESS,
  output logic                       WRITE,
  output logic [7:0]                 IMMEDIATE,
  output logic [2:0]                 ALUOP,
  output logic                       NEG_SEL,
  output logic                       IMM_SEL,
  output logic [31:0]                PC_OUT,
  output logic                       ILLEGAL
);

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ir_reg, ir_next;
  logic        fetch_req;
  logic [31:0] pc_seq, pc_target;
  ctrl_t       ctrl;
  logic        unused_ir_bits;

  instr_decoder u_decoder (
    .opcode (ir_reg[31:24]),
    .exec   (state_reg == ST_EXEC),
    .ctrl   (ctrl)
  );

  assign pc_seq    = pc_reg + PC_INC;
  assign pc_target = pc_seq + branch_offset(ir_reg[23:16]);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg <= ST_IDLE;
      pc_reg    <= RESET_PC;
      ir_reg    <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    ir_next    = ir_reg;
    fetch_req  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        state_next = ST_FETCH;
      end
      ST_FETCH: begin
        fetch_req = 1'b1;
        if (!imem.IMEM_BUSYWAIT) begin
          ir_next    = imem.IMEM_INSTR;
          state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        pc_next    = (ctrl.jump || (ctrl.beq && ZERO)) ? pc_target : pc_seq;
        state_next = ST_FETCH;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign imem.IMEM_ADDR = pc_reg;
  assign imem.IMEM_READ = fetch_req;

  assign INADDRESS   = ir_reg[18:16];
  assign OUT1ADDRESS = ir_reg[10:8];
  assign OUT2ADDRESS = ir_reg[2:0];
  assign IMMEDIATE   = ir_reg[7:0];
  assign WRITE       = ctrl.write;
  assign ALUOP       = ctrl.aluop;
  assign NEG_SEL     = ctrl.neg_sel;
  assign IMM_SEL     = ctrl.imm_sel;
  assign ILLEGAL     = ctrl.illegal;
  assign PC_OUT      = pc_reg;

  // Upper src1 bits are part of the encoding but unused by a 3-bit reg_file
  assign unused_ir_bits = ^ir_reg[15:11];

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed table-driven bench for fetch_decode_unit: two instances (RESET_PC=0
// and RESET_PC=FFFF_FFFC) sharing memory-side stimulus, one held in reset at a time.
module tb_fetch_decode_unit;
  import cpu_defs_pkg::*;

  typedef struct {
    logic [31:0] instr;
    int          busy;
    logic        zero;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        write;
    logic [2:0]  aluop;
    logic        neg;
    logic        imm_sel;
    logic        ill;
    logic [2:0]  inaddr;
    logic [2:0]  out1;
    logic [2:0]  out2;
    logic [7:0]  immv;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic        sel = 1'b0;
  logic [31:0] instr = '0;
  logic        busywait = 1'b1;
  logic        zero = 1'b0;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fetch_decode_unit_if imem_a ();
  fetch_decode_unit_if imem_b ();
  assign imem_a.IMEM_INSTR    = instr;
  assign imem_a.IMEM_BUSYWAIT = busywait;
  assign imem_b.IMEM_INSTR    = instr;
  assign imem_b.IMEM_BUSYWAIT = busywait;

  logic [2:0]  ina_a, o1_a, o2_a, alu_a, ina_b, o1_b, o2_b, alu_b;
  logic [7:0]  imm_a, imm_b;
  logic        wr_a, neg_a, isel_a, ill_a, wr_b, neg_b, isel_b, ill_b;
  logic [31:0] pc_a, pc_b;

  fetch_decode_unit #(.RESET_PC(32'h0000_0000), .PC_INC(32'd4)) dut_a (
    .CLK(clk), .RESET(rst_a), .imem(imem_a), .ZERO(zero),
    .INADDRESS(ina_a), .OUT1ADDRESS(o1_a), .OUT2ADDRESS(o2_a), .WRITE(wr_a),
    .IMMEDIATE(imm_a), .ALUOP(alu_a), .NEG_SEL(neg_a), .IMM_SEL(isel_a),
    .PC_OUT(pc_a), .ILLEGAL(ill_a)
  );

  fetch_decode_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_INC(32'd4)) dut_b (
    .CLK(clk), .RESET(rst_b), .imem(imem_b), .ZERO(zero),
    .INADDRESS(ina_b), .OUT1ADDRESS(o1_b), .OUT2ADDRESS(o2_b), .WRITE(wr_b),
    .IMMEDIATE(imm_b), .ALUOP(alu_b), .NEG_SEL(neg_b), .IMM_SEL(isel_b),
    .PC_OUT(pc_b), .ILLEGAL(ill_b)
  );

  logic [31:0] o_addr, o_pc;
  logic        o_read, o_write, o_neg, o_isel, o_ill;
  logic [2:0]  o_ina, o_o1, o_o2, o_alu;
  logic [7:0]  o_imm;

  assign o_addr  = sel ? imem_b.IMEM_ADDR : imem_a.IMEM_ADDR;
  assign o_read  = sel ? imem_b.IMEM_READ : imem_a.IMEM_READ;
  assign o_pc    = sel ? pc_b   : pc_a;
  assign o_write = sel ? wr_b   : wr_a;
  assign o_neg   = sel ? neg_b  : neg_a;
  assign o_isel  = sel ? isel_b : isel_a;
  assign o_ill   = sel ? ill_b  : ill_a;
  assign o_ina   = sel ? ina_b  : ina_a;
  assign o_o1    = sel ? o1_b   : o1_a;
  assign o_o2    = sel ? o2_b   : o2_a;
  assign o_alu   = sel ? alu_b  : alu_a;
  assign o_imm   = sel ? imm_b  : imm_a;

  vec_t vecs_a [11];
  vec_t vecs_b [2];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int n = 0;
    while (!o_read && n < 20) begin
      tick();
      n++;
    end
    chk("fetch_req", {31'd0, o_read}, 32'd1);
    chk("fetch_addr", o_addr, v.pc);
    for (int b = 0; b < v.busy; b++) begin
      busywait = 1'b1;
      instr    = 32'hFFFF_FFFF;
      tick();
      chk("busy_hold_read", {31'd0, o_read}, 32'd1);
      chk("busy_no_exec_write", {31'd0, o_write}, 32'd0);
    end
    busywait = 1'b0;
    instr    = v.instr;
    zero     = v.zero;
    tick();
    busywait = 1'b1;
    instr    = 32'hFFFF_FFFF;
    chk("exec_read_low", {31'd0, o_read}, 32'd0);
    chk("write",   {31'd0, o_write}, {31'd0, v.write});
    chk("aluop",   {29'd0, o_alu},   {29'd0, v.aluop});
    chk("neg_sel", {31'd0, o_neg},   {31'd0, v.neg});
    chk("imm_sel", {31'd0, o_isel},  {31'd0, v.imm_sel});
    chk("illegal", {31'd0, o_ill},   {31'd0, v.ill});
    chk("inaddr",  {29'd0, o_ina},   {29'd0, v.inaddr});
    chk("out1",    {29'd0, o_o1},    {29'd0, v.out1});
    chk("out2",    {29'd0, o_o2},    {29'd0, v.out2});
    chk("immed",   {24'd0, o_imm},   {24'd0, v.immv});
    tick();
    chk("next_pc", o_pc, v.next_pc);
    chk("post_write_low", {31'd0, o_write}, 32'd0);
    chk("post_illegal_low", {31'd0, o_ill}, 32'd0);
    $display("[TB] dut=%0d vec %0d instr=%h pc=%h next_pc=%h (expected %h)",
             sel, idx, v.instr, v.pc, o_pc, v.next_pc);
  endtask

  initial begin
    //               instr         busy zero pc            next          wr alu    neg is il ina  o1   o2   imm
    vecs_a[0]  = '{32'h0004_0005, 3, 0, 32'd0,  32'd4,  1, 3'd0, 0, 1, 0, 3'd4, 3'd0, 3'd5, 8'h05};
    vecs_a[1]  = '{32'h0301_0203, 0, 0, 32'd4,  32'd8,  1, 3'd1, 1, 0, 0, 3'd1, 3'd2, 3'd3, 8'h03};
    vecs_a[2]  = '{32'h07FE_0102, 0, 1, 32'd8,  32'd4,  0, 3'd1, 1, 0, 0, 3'd6, 3'd1, 3'd2, 8'h02};
    vecs_a[3]  = '{32'h0102_0300, 0, 0, 32'd4,  32'd8,  1, 3'd0, 0, 0, 0, 3'd2, 3'd3, 3'd0, 8'h00};
    vecs_a[4]  = '{32'h07FE_0102, 2, 0, 32'd8,  32'd12, 0, 3'd1, 1, 0, 0, 3'd6, 3'd1, 3'd2, 8'h02};
    vecs_a[5]  = '{32'h0205_0607, 1, 0, 32'd12, 32'd16, 1, 3'd1, 0, 0, 0, 3'd5, 3'd6, 3'd7, 8'h07};
    vecs_a[6]  = '{32'h0400_0001, 0, 0, 32'd16, 32'd20, 1, 3'd2, 0, 0, 0, 3'd0, 3'd0, 3'd1, 8'h01};
    vecs_a[7]  = '{32'h0503_0402, 0, 1, 32'd20, 32'd24, 1, 3'd3, 0, 0, 0, 3'd3, 3'd4, 3'd2, 8'h02};
    vecs_a[8]  = '{32'h0602_0000, 0, 0, 32'd24, 32'd36, 0, 3'd0, 0, 0, 0, 3'd2, 3'd0, 3'd0, 8'h00};
    vecs_a[9]  = '{32'h2000_0000, 0, 1, 32'd36, 32'd40, 0, 3'd0, 0, 0, 1, 3'd0, 3'd0, 3'd0, 8'h00};
    vecs_a[10] = '{32'h06FF_0000, 1, 0, 32'd40, 32'd40, 0, 3'd0, 0, 0, 0, 3'd7, 3'd0, 3'd0, 8'h00};
    vecs_b[0]  = '{32'h0201_0203, 0, 0, 32'hFFFF_FFFC, 32'd0, 1, 3'd1, 0, 0, 0, 3'd1, 3'd2, 3'd3, 8'h03};
    vecs_b[1]  = '{32'h2011_2233, 1, 1, 32'd0,  32'd4,  0, 3'd0, 0, 0, 1, 3'd1, 3'd2, 3'd3, 8'h33};

    // Reset held for two cycles, then IDLE -> FETCH
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_read", {31'd0, o_read}, 32'd0);
      chk("rst_pc", o_pc, 32'd0);
      chk("rst_write", {31'd0, o_write}, 32'd0);
    end
    rst_a = 1'b0;
    chk("idle_read", {31'd0, o_read}, 32'd0);
    tick();
    chk("first_fetch_read", {31'd0, o_read}, 32'd1);
    chk("first_fetch_addr", o_addr, 32'd0);

    for (int i = 0; i < 11; i++) run_vec(i, vecs_a[i]);

    // Asynchronous reset in the middle of a stalled fetch
    busywait = 1'b1;
    #3;
    rst_a = 1'b1;
    #1;
    chk("async_rst_read", {31'd0, o_read}, 32'd0);
    chk("async_rst_pc", o_pc, 32'd0);
    chk("async_rst_write", {31'd0, o_write}, 32'd0);
    chk("async_rst_ir", {29'd0, o_ina}, 32'd0);
    busywait = 1'b0;
    instr    = 32'h0203_0405;
    tick();
    chk("rst_no_ir_load", {29'd0, o_ina}, 32'd0);
    chk("rst_hold_read", {31'd0, o_read}, 32'd0);
    busywait = 1'b1;
    rst_a = 1'b0;
    tick();
    chk("refetch_addr", o_addr, 32'd0);
    chk("refetch_read", {31'd0, o_read}, 32'd1);

    // Second instance: PC wrap and illegal opcode
    rst_a = 1'b1;
    sel   = 1'b1;
    tick();
    chk("b_rst_pc", o_pc, 32'hFFFF_FFFC);
    rst_b = 1'b0;
    for (int i = 0; i < 2; i++) run_vec(i, vecs_b[i]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #50000;
    $display("[TB] FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
